// File: rtl/inst_align_buffer.sv
// Fetch-side realigner: turns an IF-stage halfword-aligned PC into RV32I/RVC instructions
// using a one-word line buffer so that instructions straddling two cache words can be assembled.
module inst_align_buffer #(
    parameter int ADDR_W = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pc,
    output logic              ready,
    output logic              compressed,
    output logic [31:0]       inst,
    input  logic              ICACHE_stall,
    output logic              ICACHE_ren,
    output logic              ICACHE_wen,
    output logic [ADDR_W-1:0] ICACHE_addr,
    output logic [31:0]       ICACHE_wdata,
    input  logic [31:0]       ICACHE_rdata
);

    typedef enum logic {
        S_RUN,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              buf_vld_q, buf_vld_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [31:0]       buf_data_q, buf_data_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;

    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] word_addr_next;
    logic              hit;
    logic [15:0]       half;
    logic              ren_raw;
    logic              rdy_raw;
    logic [31:0]       raw_inst;
    logic              unused_pc0;

    assign unused_pc0     = pc[0];
    assign word_addr      = pc[ADDR_W+1:2];
    assign word_addr_next = word_addr + ADDR_W'(1);
    assign hit            = buf_vld_q && (buf_addr_q == word_addr);

    always_comb begin
        state_d     = state_q;
        buf_vld_d   = buf_vld_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        req_addr_d  = req_addr_q;
        ren_raw     = 1'b0;
        rdy_raw     = 1'b0;
        raw_inst    = 32'h0;
        half        = 16'h0;
        ICACHE_addr = word_addr;

        case (state_q)
            S_RUN: begin
                if (hit) begin
                    half = pc[1] ? buf_data_q[31:16] : buf_data_q[15:0];
                    if (pc[1] && (half[1:0] == 2'b11)) begin
                        // Upper half lives in the next word; that word becomes the new buffer.
                        ren_raw     = 1'b1;
                        ICACHE_addr = word_addr_next;
                        if (!ICACHE_stall) begin
                            rdy_raw    = 1'b1;
                            raw_inst   = {ICACHE_rdata[15:0], buf_data_q[31:16]};
                            buf_vld_d  = 1'b1;
                            buf_addr_d = word_addr_next;
                            buf_data_d = ICACHE_rdata;
                        end
                    end else begin
                        rdy_raw  = 1'b1;
                        raw_inst = pc[1] ? {16'h0, buf_data_q[31:16]} : buf_data_q;
                    end
                end else begin
                    ren_raw     = 1'b1;
                    ICACHE_addr = word_addr;
                    if (!ICACHE_stall) begin
                        buf_vld_d  = 1'b1;
                        buf_addr_d = word_addr;
                        buf_data_d = ICACHE_rdata;
                        half       = pc[1] ? ICACHE_rdata[31:16] : ICACHE_rdata[15:0];
                        if (!(pc[1] && (half[1:0] == 2'b11))) begin
                            rdy_raw  = 1'b1;
                            raw_inst = pc[1] ? {16'h0, ICACHE_rdata[31:16]} : ICACHE_rdata;
                        end
                    end
                end
                if (ren_raw && ICACHE_stall) begin
                    req_addr_d = ICACHE_addr;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // The outstanding request is held unchanged even if the PC redirects.
                ren_raw     = 1'b1;
                ICACHE_addr = req_addr_q;
                if (!ICACHE_stall) begin
                    buf_vld_d  = 1'b1;
                    buf_addr_d = req_addr_q;
                    buf_data_d = ICACHE_rdata;
                    state_d    = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    assign ready        = rst_n && rdy_raw;
    assign ICACHE_ren   = rst_n && ren_raw;
    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = 32'h0;
    assign compressed   = ready && (raw_inst[1:0] != 2'b11);
    assign inst         = !ready ? 32'h0 :
                          (raw_inst[1:0] == 2'b11) ? raw_inst : {16'h0, raw_inst[15:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= 32'h0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            buf_vld_q  <= buf_vld_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            req_addr_q <= req_addr_d;
        end
    end

endmodule

// File: tb/tb_inst_align_buffer.sv
// Directed testbench for inst_align_buffer with a small combinational ICACHE model.
module tb_inst_align_buffer;

    localparam int ADDR_W = 30;

    logic              clk;
    logic              rst_n;
    logic [31:0]       pc;
    logic              ready;
    logic              compressed;
    logic [31:0]       inst;
    logic              ICACHE_stall;
    logic              ICACHE_ren;
    logic              ICACHE_wen;
    logic [ADDR_W-1:0] ICACHE_addr;
    logic [31:0]       ICACHE_wdata;
    logic [31:0]       ICACHE_rdata;

    logic [31:0] mem [0:63];
    int checks = 0;
    int errors = 0;

    inst_align_buffer #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .ready        (ready),
        .compressed   (compressed),
        .inst         (inst),
        .ICACHE_stall (ICACHE_stall),
        .ICACHE_ren   (ICACHE_ren),
        .ICACHE_wen   (ICACHE_wen),
        .ICACHE_addr  (ICACHE_addr),
        .ICACHE_wdata (ICACHE_wdata),
        .ICACHE_rdata (ICACHE_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache returns garbage while stalled so stale data cannot sneak into the buffer.
    always_comb ICACHE_rdata = ICACHE_stall ? 32'hDEADBEEF : mem[ICACHE_addr[5:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc = 32'h0; ICACHE_stall = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_pre: got %b expected 0", ready); end
        checks++; if (ICACHE_ren !== 1'b0) begin errors++; $display("[TB] FAIL reset_ren_pre: got %b expected 0", ICACHE_ren); end
        tick(); tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (ICACHE_ren !== 1'b0) begin errors++; $display("[TB] FAIL reset_ren: got %b expected 0", ICACHE_ren); end
        checks++; if (ICACHE_wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen: got %b expected 0", ICACHE_wen); end
        checks++; if (ICACHE_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", ICACHE_wdata); end
        rst_n = 1'b1;
    endtask

    task automatic test_seq32();
        pc = 32'h0; ICACHE_stall = 1'b0;
        #1;
        checks++; if (ICACHE_ren !== 1'b1) begin errors++; $display("[TB] FAIL t1_ren: got %b expected 1", ICACHE_ren); end
        checks++; if (ICACHE_addr !== 30'd0) begin errors++; $display("[TB] FAIL t1_addr: got %h expected 0", ICACHE_addr); end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL t1_ready: got %b expected 1", ready); end
        checks++; if (inst !== 32'h00500093) begin errors++; $display("[TB] FAIL t1_inst: got %h expected 00500093", inst); end
        checks++; if (compressed !== 1'b0) begin errors++; $display("[TB] FAIL t1_compressed: got %b expected 0", compressed); end
        tick();
    endtask

    task automatic test_rvc_pair();
        pc = 32'h0000000C;
        #1;
        checks++; if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'd3) begin errors++; $display("[TB] FAIL t2_miss_req: got ren=%b addr=%h expected ren=1 addr=3", ICACHE_ren, ICACHE_addr); end
        checks++; if (ready !== 1'b1 || inst !== 32'h00000001) begin errors++; $display("[TB] FAIL t2_lo_inst: got ready=%b inst=%h expected ready=1 inst=00000001", ready, inst); end
        checks++; if (compressed !== 1'b1) begin errors++; $display("[TB] FAIL t2_lo_compressed: got %b expected 1", compressed); end
        tick();
        pc = 32'h0000000E;
        #1;
        checks++; if (ICACHE_ren !== 1'b0) begin errors++; $display("[TB] FAIL t2_hit_ren: got %b expected 0", ICACHE_ren); end
        checks++; if (ready !== 1'b1 || inst !== 32'h00004001) begin errors++; $display("[TB] FAIL t2_hi_inst: got ready=%b inst=%h expected ready=1 inst=00004001", ready, inst); end
        checks++; if (compressed !== 1'b1) begin errors++; $display("[TB] FAIL t2_hi_compressed: got %b expected 1", compressed); end
        tick();
    endtask

    task automatic test_straddle();
        pc = 32'h00000006;
        #1;
        checks++; if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'd1) begin errors++; $display("[TB] FAIL t3_miss_req: got ren=%b addr=%h expected ren=1 addr=1", ICACHE_ren, ICACHE_addr); end
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL t3_miss_ready: got %b expected 0", ready); end
        tick();
        checks++; if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'd2) begin errors++; $display("[TB] FAIL t3_next_req: got ren=%b addr=%h expected ren=1 addr=2", ICACHE_ren, ICACHE_addr); end
        checks++; if (ready !== 1'b1 || inst !== 32'h00500093) begin errors++; $display("[TB] FAIL t3_inst: got ready=%b inst=%h expected ready=1 inst=00500093", ready, inst); end
        checks++; if (compressed !== 1'b0) begin errors++; $display("[TB] FAIL t3_compressed: got %b expected 0", compressed); end
        tick();
        pc = 32'h00000008;
        #1;
        checks++; if (ICACHE_ren !== 1'b0 || ready !== 1'b1 || inst !== 32'h00000050) begin errors++; $display("[TB] FAIL t3_buf_word2: got ren=%b ready=%b inst=%h expected ren=0 ready=1 inst=00000050", ICACHE_ren, ready, inst); end
        tick();
    endtask

    task automatic test_stall();
        pc = 32'h00000014; ICACHE_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'd5 || ready !== 1'b0) begin errors++; $display("[TB] FAIL t4_stall_%0d: got ren=%b addr=%h ready=%b expected ren=1 addr=5 ready=0", i, ICACHE_ren, ICACHE_addr, ready); end
            tick();
        end
        ICACHE_stall = 1'b0;
        #1;
        checks++; if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'd5 || ready !== 1'b0) begin errors++; $display("[TB] FAIL t4_fill: got ren=%b addr=%h ready=%b expected ren=1 addr=5 ready=0", ICACHE_ren, ICACHE_addr, ready); end
        tick();
        checks++; if (ICACHE_ren !== 1'b0 || ready !== 1'b1 || inst !== 32'h00A00113) begin errors++; $display("[TB] FAIL t4_after: got ren=%b ready=%b inst=%h expected ren=0 ready=1 inst=00a00113", ICACHE_ren, ready, inst); end
        tick();
    endtask

    task automatic test_redirect();
        pc = 32'h00000010; ICACHE_stall = 1'b1;
        #1;
        checks++; if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'd4) begin errors++; $display("[TB] FAIL t5_req: got ren=%b addr=%h expected ren=1 addr=4", ICACHE_ren, ICACHE_addr); end
        tick();
        pc = 32'h00000080;
        #1;
        checks++; if (ICACHE_addr !== 30'd4 || ready !== 1'b0) begin errors++; $display("[TB] FAIL t5_hold: got addr=%h ready=%b expected addr=4 ready=0", ICACHE_addr, ready); end
        tick();
        ICACHE_stall = 1'b0;
        #1;
        checks++; if (ICACHE_addr !== 30'd4 || ready !== 1'b0) begin errors++; $display("[TB] FAIL t5_fill: got addr=%h ready=%b expected addr=4 ready=0", ICACHE_addr, ready); end
        tick();
        checks++; if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'h20) begin errors++; $display("[TB] FAIL t5_new_req: got ren=%b addr=%h expected ren=1 addr=20", ICACHE_ren, ICACHE_addr); end
        checks++; if (ready !== 1'b1 || inst !== 32'h02A00513) begin errors++; $display("[TB] FAIL t5_inst: got ready=%b inst=%h expected ready=1 inst=02a00513", ready, inst); end
        tick();
    endtask

    task automatic test_reset_wait();
        pc = 32'h00000084; ICACHE_stall = 1'b1;
        #1;
        checks++; if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'h21) begin errors++; $display("[TB] FAIL t6_req: got ren=%b addr=%h expected ren=1 addr=21", ICACHE_ren, ICACHE_addr); end
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (ICACHE_ren !== 1'b0 || ready !== 1'b0) begin errors++; $display("[TB] FAIL t6_rst_low: got ren=%b ready=%b expected ren=0 ready=0", ICACHE_ren, ready); end
        tick();
        checks++; if (ICACHE_ren !== 1'b0 || ready !== 1'b0) begin errors++; $display("[TB] FAIL t6_rst_edge: got ren=%b ready=%b expected ren=0 ready=0", ICACHE_ren, ready); end
        rst_n = 1'b1; ICACHE_stall = 1'b0; pc = 32'h00000080;
        #1;
        checks++; if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'h20) begin errors++; $display("[TB] FAIL t6_refetch: got ren=%b addr=%h expected ren=1 addr=20", ICACHE_ren, ICACHE_addr); end
        checks++; if (ready !== 1'b1 || inst !== 32'h02A00513) begin errors++; $display("[TB] FAIL t6_inst: got ready=%b inst=%h expected ready=1 inst=02a00513", ready, inst); end
        tick();
    endtask

    task automatic test_wrap();
        pc = 32'hFFFFFFFE; ICACHE_stall = 1'b0;
        #1;
        checks++; if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'h3FFFFFFF || ready !== 1'b0) begin errors++; $display("[TB] FAIL wrap_miss: got ren=%b addr=%h ready=%b expected ren=1 addr=3fffffff ready=0", ICACHE_ren, ICACHE_addr, ready); end
        tick();
        checks++; if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'd0) begin errors++; $display("[TB] FAIL wrap_next_req: got ren=%b addr=%h expected ren=1 addr=0", ICACHE_ren, ICACHE_addr); end
        checks++; if (ready !== 1'b1 || inst !== 32'h00930513 || compressed !== 1'b0) begin errors++; $display("[TB] FAIL wrap_inst: got ready=%b inst=%h c=%b expected ready=1 inst=00930513 c=0", ready, inst, compressed); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h00010001;
        mem[0]  = 32'h00500093;
        mem[1]  = 32'h00930001;
        mem[2]  = 32'h12340050;
        mem[3]  = 32'h40010001;
        mem[5]  = 32'h00A00113;
        mem[32] = 32'h02A00513;
        mem[63] = 32'h05130001;
        rst_n = 1'b0; pc = 32'h0; ICACHE_stall = 1'b0;

        test_reset();
        test_seq32();
        test_rvc_pair();
        test_straddle();
        test_stall();
        test_redirect();
        test_reset_wait();
        test_wrap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
